// File: rtl/prefetcher_pkg.sv
// Shared definitions for the multi-stream stride prefetcher: stream states,
// prefetch-port opcodes and default widths.
package prefetcher_pkg;

    localparam int DEF_ADDR_BITS       = 64;
    localparam int DEF_BURST_LEN_WIDTH = 8;
    localparam int DEF_TID_WIDTH       = 8;
    localparam int DEF_NUM_STREAMS     = 4;
    localparam int DEF_LOG_QUEUE_SIZE  = 6;
    localparam int DEF_WATCHDOG_SIZE   = 10;
    localparam int DEF_CONF_BITS       = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAIN,
        S_ACTIVE,
        S_CLEANUP
    } stream_state_e;

    typedef enum logic [1:0] {
        PF_OP_HOLD,
        PF_OP_ISSUE,
        PF_OP_RETIRE
    } pf_op_e;

endpackage

// File: rtl/clkDivN.sv
// Free-running prescaler: emits a one-cycle tick every max(div,1) enabled cycles.
module clkDivN #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] last;

    assign last = (div == '0) ? '0 : div - WIDTH'(1);
    assign tick = en && (cnt >= last);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + WIDTH'(1);
    end

endmodule

// File: rtl/multi_stream_prefetch_ctrl.sv
// Stride-detecting prefetch controller: trains per-ID streams on observed reads
// and issues round-robin arbitrated prefetch requests through a registered port.
module multi_stream_prefetch_ctrl
    import prefetcher_pkg::*;
#(
    parameter int ADDR_BITS       = DEF_ADDR_BITS,
    parameter int BURST_LEN_WIDTH = DEF_BURST_LEN_WIDTH,
    parameter int TID_WIDTH       = DEF_TID_WIDTH,
    parameter int NUM_STREAMS     = DEF_NUM_STREAMS,
    parameter int LOG_QUEUE_SIZE  = DEF_LOG_QUEUE_SIZE,
    parameter int WATCHDOG_SIZE   = DEF_WATCHDOG_SIZE,
    parameter int CONF_BITS       = DEF_CONF_BITS
) (
    input  logic                                          clk,
    input  logic                                          resetN,
    input  logic                                          en,
    input  logic                                          flushN,
    input  logic                                          obs_valid,
    input  logic [ADDR_BITS-1:0]                          obs_addr,
    input  logic [TID_WIDTH-1:0]                          obs_id,
    input  logic [BURST_LEN_WIDTH-1:0]                    obs_len,
    input  logic [ADDR_BITS-1:0]                          bar,
    input  logic [ADDR_BITS-1:0]                          limit,
    input  logic [LOG_QUEUE_SIZE:0]                       windowSize,
    input  logic [CONF_BITS-1:0]                          confThreshold,
    input  logic [WATCHDOG_SIZE-1:0]                      watchdogCnt,
    input  logic [NUM_STREAMS*(LOG_QUEUE_SIZE+1)-1:0]     str_reqCnt,
    input  logic [NUM_STREAMS-1:0]                        str_drained,
    output logic                                          pf_valid,
    input  logic                                          pf_ready,
    output logic [ADDR_BITS-1:0]                          pf_addr,
    output logic [BURST_LEN_WIDTH-1:0]                    pf_len,
    output logic [TID_WIDTH-1:0]                          pf_id,
    output logic [$clog2(NUM_STREAMS)-1:0]                pf_stream,
    output logic [NUM_STREAMS-1:0]                        str_flushN,
    output logic [NUM_STREAMS-1:0]                        str_active
);

    localparam int SW = $clog2(NUM_STREAMS);
    localparam int QW = LOG_QUEUE_SIZE + 1;

    logic                       wd_tick;
    logic                       in_range;
    logic                       accept;
    logic                       alloc_found;
    logic                       grant_found;
    logic [SW-1:0]              grant;
    logic [SW-1:0]              rr_ptr;
    pf_op_e                     pf_op;
    logic [NUM_STREAMS-1:0]     match_vec;
    logic [NUM_STREAMS-1:0]     hit_vec;
    logic [NUM_STREAMS-1:0]     idle_vec;
    logic [NUM_STREAMS-1:0]     alloc_vec;
    logic [NUM_STREAMS-1:0]     elig_vec;
    logic [NUM_STREAMS-1:0]     flush_pulse;
    logic [ADDR_BITS-1:0]       pfa_arr [NUM_STREAMS];
    logic [BURST_LEN_WIDTH-1:0] len_arr [NUM_STREAMS];
    logic [TID_WIDTH-1:0]       id_arr  [NUM_STREAMS];

    clkDivN #(.WIDTH(WATCHDOG_SIZE)) u_watchdog (
        .clk   (clk),
        .resetN(resetN),
        .en    (en),
        .div   (watchdogCnt),
        .tick  (wd_tick)
    );

    assign in_range = obs_valid && (obs_addr >= bar) && (obs_addr <= limit);
    assign accept   = en && pf_valid && pf_ready;

    always_comb begin
        alloc_vec   = '0;
        alloc_found = 1'b0;
        if (en && in_range && flushN && (match_vec == '0)) begin
            for (int k = 0; k < NUM_STREAMS; k++) begin
                if (!alloc_found && idle_vec[k]) begin
                    alloc_found  = 1'b1;
                    alloc_vec[k] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_str
        stream_state_e              st;
        logic [ADDR_BITS-1:0]       last_addr;
        logic [ADDR_BITS-1:0]       stride;
        logic [ADDR_BITS-1:0]       pf_addr_q;
        logic [ADDR_BITS-1:0]       delta;
        logic [ADDR_BITS-1:0]       stride_n;
        logic [TID_WIDTH-1:0]       sid;
        logic [BURST_LEN_WIDTH-1:0] slen;
        logic [CONF_BITS-1:0]       conf;
        logic [CONF_BITS-1:0]       conf_n;
        logic [1:0]                 idle_cnt;
        logic                       same;
        logic                       wd_expire;
        logic                       brk;

        assign match_vec[i] = obs_valid && (st != S_IDLE) && (obs_id == sid);
        assign hit_vec[i]   = in_range && match_vec[i];
        assign idle_vec[i]  = (st == S_IDLE);
        // Modular subtraction yields two's-complement strides for descending streams
        assign delta        = obs_addr - last_addr;
        assign same         = (delta == stride);
        assign stride_n     = same ? stride : delta;
        assign conf_n       = !same ? '0 : ((&conf) ? conf : conf + CONF_BITS'(1));
        assign wd_expire    = wd_tick && !hit_vec[i] && (idle_cnt == 2'd2);
        assign brk          = (hit_vec[i] && (delta != '0) && !same) ||
                              (match_vec[i] && ((obs_len != slen) || !in_range));
        assign elig_vec[i]  = (st == S_ACTIVE) && (str_reqCnt[i*QW +: QW] < windowSize) &&
                              (pf_addr_q >= bar) && (pf_addr_q <= limit);
        assign flush_pulse[i] = en && (st == S_CLEANUP) && str_drained[i];
        assign str_active[i]  = (st == S_ACTIVE);
        assign pfa_arr[i]     = pf_addr_q;
        assign len_arr[i]     = slen;
        assign id_arr[i]      = sid;

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                st        <= S_IDLE;
                last_addr <= '0;
                stride    <= '0;
                pf_addr_q <= '0;
                conf      <= '0;
                sid       <= '0;
                slen      <= '0;
                idle_cnt  <= '0;
            end else if (en) begin
                if (accept && (pf_stream == SW'(i)))
                    pf_addr_q <= pf_addr_q + stride;
                if (st != S_IDLE) begin
                    if (hit_vec[i])
                        idle_cnt <= '0;
                    else if (wd_tick && (idle_cnt != 2'd3))
                        idle_cnt <= idle_cnt + 2'd1;
                end
                if (hit_vec[i])
                    last_addr <= obs_addr;
                unique case (st)
                    S_IDLE: if (alloc_vec[i]) begin
                        st        <= S_TRAIN;
                        last_addr <= obs_addr;
                        sid       <= obs_id;
                        slen      <= obs_len;
                        stride    <= '0;
                        conf      <= '0;
                        idle_cnt  <= '0;
                    end
                    S_TRAIN: begin
                        if (!flushN || wd_expire) begin
                            st <= S_CLEANUP;
                        end else if (hit_vec[i] && (delta != '0)) begin
                            stride <= stride_n;
                            conf   <= conf_n;
                            if (conf_n >= confThreshold) begin
                                st        <= S_ACTIVE;
                                pf_addr_q <= obs_addr + stride_n;
                            end
                        end
                    end
                    S_ACTIVE:  if (!flushN || wd_expire || brk) st <= S_CLEANUP;
                    S_CLEANUP: if (str_drained[i]) st <= S_IDLE;
                    default:   st <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            str_flushN <= '1;
        else
            str_flushN <= ~flush_pulse;
    end

    // Round-robin search starting at rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant       = rr_ptr;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            if (!grant_found && elig_vec[rr_ptr + SW'(k)]) begin
                grant_found = 1'b1;
                grant       = rr_ptr + SW'(k);
            end
        end
    end

    always_comb begin
        pf_op = PF_OP_HOLD;
        if (accept)
            pf_op = PF_OP_RETIRE;
        else if (en && !pf_valid && grant_found)
            pf_op = PF_OP_ISSUE;
    end

    // Request is captured only while the port is empty, so it stays frozen under backpressure
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pf_valid  <= 1'b0;
            pf_addr   <= '0;
            pf_len    <= '0;
            pf_id     <= '0;
            pf_stream <= '0;
            rr_ptr    <= '0;
        end else begin
            unique case (pf_op)
                PF_OP_ISSUE: begin
                    pf_valid  <= 1'b1;
                    pf_addr   <= pfa_arr[grant];
                    pf_len    <= len_arr[grant];
                    pf_id     <= id_arr[grant];
                    pf_stream <= grant;
                end
                PF_OP_RETIRE: begin
                    pf_valid <= 1'b0;
                    rr_ptr   <= pf_stream + SW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_stream_prefetch_ctrl.sv
// Directed bench for multi_stream_prefetch_ctrl with an in-order scoreboard of
// expected prefetch requests.
module tb_multi_stream_prefetch_ctrl;

    localparam int AW = 64;
    localparam int LW = 8;
    localparam int TW = 8;
    localparam int NS = 4;
    localparam int LQ = 6;
    localparam int WD = 10;
    localparam int CB = 2;
    localparam int QW = LQ + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [TW-1:0] id;
        logic [1:0]    stream;
    } exp_t;

    logic             clk = 1'b0;
    logic             resetN = 1'b1;
    logic             en = 1'b1;
    logic             flushN = 1'b1;
    logic             obs_valid = 1'b0;
    logic [AW-1:0]    obs_addr = '0;
    logic [TW-1:0]    obs_id = '0;
    logic [LW-1:0]    obs_len = '0;
    logic [AW-1:0]    bar = '0;
    logic [AW-1:0]    limit = '1;
    logic [LQ:0]      windowSize = 7'd4;
    logic [CB-1:0]    confThreshold = 2'd1;
    logic [WD-1:0]    watchdogCnt = 10'd1023;
    logic [NS*QW-1:0] str_reqCnt = '0;
    logic [NS-1:0]    str_drained = '0;
    logic             pf_valid;
    logic             pf_ready = 1'b1;
    logic [AW-1:0]    pf_addr;
    logic [LW-1:0]    pf_len;
    logic [TW-1:0]    pf_id;
    logic [1:0]       pf_stream;
    logic [NS-1:0]    str_flushN;
    logic [NS-1:0]    str_active;

    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];

    multi_stream_prefetch_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .en           (en),
        .flushN       (flushN),
        .obs_valid    (obs_valid),
        .obs_addr     (obs_addr),
        .obs_id       (obs_id),
        .obs_len      (obs_len),
        .bar          (bar),
        .limit        (limit),
        .windowSize   (windowSize),
        .confThreshold(confThreshold),
        .watchdogCnt  (watchdogCnt),
        .str_reqCnt   (str_reqCnt),
        .str_drained  (str_drained),
        .pf_valid     (pf_valid),
        .pf_ready     (pf_ready),
        .pf_addr      (pf_addr),
        .pf_len       (pf_len),
        .pf_id        (pf_id),
        .pf_stream    (pf_stream),
        .str_flushN   (str_flushN),
        .str_active   (str_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [TW-1:0] id, input logic [1:0] s);
        exp_t e;
        e.addr = a; e.len = l; e.id = id; e.stream = s;
        sbq.push_back(e);
    endtask

    // Scores any handshake that completes at the coming edge, then advances one cycle.
    task automatic clk1();
        if (pf_valid && pf_ready && en) begin
            chk("sb_pending", 64'(sbq.size() > 0), 64'd1);
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("pf_addr", pf_addr, e.addr);
                chk("pf_len", 64'(pf_len), 64'(e.len));
                chk("pf_id", 64'(pf_id), 64'(e.id));
                chk("pf_stream", 64'(pf_stream), 64'(e.stream));
            end
            str_reqCnt[pf_stream*QW +: QW] = str_reqCnt[pf_stream*QW +: QW] + 7'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic obs(input logic [AW-1:0] a, input logic [TW-1:0] id, input logic [LW-1:0] l);
        obs_valid = 1'b1; obs_addr = a; obs_id = id; obs_len = l;
        clk1();
        obs_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        obs_valid = 1'b0; flushN = 1'b1; en = 1'b1; pf_ready = 1'b1;
        bar = '0; limit = '1; windowSize = 7'd4; confThreshold = 2'd1;
        watchdogCnt = 10'd1023; str_reqCnt = '0; str_drained = '0;
        sbq.delete();
        #2;
        chk("rst_pf_valid", 64'(pf_valid), 64'd0);
        chk("rst_pf_addr", pf_addr, 64'd0);
        chk("rst_pf_stream", 64'(pf_stream), 64'd0);
        chk("rst_flushN", 64'(str_flushN), 64'hF);
        chk("rst_active", 64'(str_active), 64'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        #1;
        // Activation, positive stride, window limit
        do_reset();
        obs(64'h1000, 8'd3, 8'd8);
        obs(64'h1040, 8'd3, 8'd8);
        chk("train_not_active", 64'(str_active), 64'd0);
        obs(64'h1080, 8'd3, 8'd8);
        chk("act_s0", 64'(str_active), 64'h1);
        push(64'h10C0, 8'd8, 8'd3, 2'd0);
        push(64'h1100, 8'd8, 8'd3, 2'd0);
        push(64'h1140, 8'd8, 8'd3, 2'd0);
        push(64'h1180, 8'd8, 8'd3, 2'd0);
        repeat (30) clk1();
        chk("win_sb_empty", 64'(sbq.size()), 64'd0);
        chk("win_no_valid", 64'(pf_valid), 64'd0);

        // Negative stride bounded below by bar
        do_reset();
        bar = 64'h1F40; limit = 64'hFFFF;
        obs(64'h2000, 8'd5, 8'd4);
        obs(64'h1FC0, 8'd5, 8'd4);
        obs(64'h1F80, 8'd5, 8'd4);
        chk("neg_act", 64'(str_active), 64'h1);
        push(64'h1F40, 8'd4, 8'd5, 2'd0);
        repeat (20) clk1();
        chk("neg_sb_empty", 64'(sbq.size()), 64'd0);
        chk("neg_no_valid", 64'(pf_valid), 64'd0);

        // Round-robin with a backpressure stall
        do_reset();
        pf_ready = 1'b0;
        obs(64'h4000, 8'd1, 8'd8);
        obs(64'h4040, 8'd1, 8'd8);
        obs(64'h4080, 8'd1, 8'd8);
        obs(64'h8000, 8'd2, 8'd16);
        obs(64'h8100, 8'd2, 8'd16);
        obs(64'h8200, 8'd2, 8'd16);
        chk("rr_both_act", 64'(str_active), 64'h3);
        for (int c = 0; c < 5; c++) begin
            clk1();
            chk("stall_valid", 64'(pf_valid), 64'd1);
            chk("stall_addr", pf_addr, 64'h40C0);
        end
        chk("stall_stream", 64'(pf_stream), 64'd0);
        chk("stall_id", 64'(pf_id), 64'd1);
        chk("stall_len", 64'(pf_len), 64'd8);
        for (int k = 0; k < 4; k++) begin
            push(64'h40C0 + 64'(k) * 64'h40, 8'd8, 8'd1, 2'd0);
            push(64'h8300 + 64'(k) * 64'h100, 8'd16, 8'd2, 2'd1);
        end
        pf_ready = 1'b1;
        repeat (30) clk1();
        chk("rr_sb_empty", 64'(sbq.size()), 64'd0);

        // Stride break, drain handshake, return to IDLE
        do_reset();
        windowSize = 7'd0;
        obs(64'h1000, 8'd7, 8'd8);
        obs(64'h1040, 8'd7, 8'd8);
        obs(64'h1080, 8'd7, 8'd8);
        chk("brk_act", 64'(str_active), 64'h1);
        obs(64'h1100, 8'd7, 8'd8);
        chk("brk_cleanup", 64'(str_active), 64'd0);
        repeat (3) clk1();
        chk("brk_wait_drain", 64'(str_flushN), 64'hF);
        str_drained = 4'h1;
        clk1();
        str_drained = 4'h0;
        chk("brk_pulse", 64'(str_flushN), 64'hE);
        clk1();
        chk("brk_pulse_end", 64'(str_flushN), 64'hF);
        obs(64'h5000, 8'd9, 8'd8);
        obs(64'h5040, 8'd9, 8'd8);
        obs(64'h5080, 8'd9, 8'd8);
        chk("brk_realloc", 64'(str_active), 64'h1);

        // Slot overflow and global flush
        do_reset();
        windowSize = 7'd0;
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 3; j++)
                obs(64'((k + 1) * 'h10000 + j * 'h40), 8'(10 + k), 8'd8);
        chk("ovf_all_act", 64'(str_active), 64'hF);
        str_drained = 4'hF;
        flushN = 1'b0;
        clk1();
        flushN = 1'b1;
        chk("flush_cleanup", 64'(str_active), 64'd0);
        chk("flush_no_pulse_yet", 64'(str_flushN), 64'hF);
        clk1();
        chk("flush_pulse", 64'(str_flushN), 64'h0);
        clk1();
        chk("flush_pulse_end", 64'(str_flushN), 64'hF);
        str_drained = 4'h0;
        for (int j = 0; j < 3; j++)
            obs(64'h50000 + 64'(j) * 64'h40, 8'd14, 8'd8);
        chk("ovf_later_alloc", 64'(str_active), 64'h1);

        // Watchdog expiry
        do_reset();
        windowSize = 7'd0;
        watchdogCnt = 10'd2;
        obs(64'h7000, 8'd4, 8'd8);
        obs(64'h7040, 8'd4, 8'd8);
        obs(64'h7080, 8'd4, 8'd8);
        repeat (4) clk1();
        chk("wd_still_act", 64'(str_active), 64'h1);
        repeat (2) clk1();
        chk("wd_expired", 64'(str_active), 64'h0);

        // Reset while a request is pending
        do_reset();
        pf_ready = 1'b0;
        obs(64'h3000, 8'd6, 8'd8);
        obs(64'h3040, 8'd6, 8'd8);
        obs(64'h3080, 8'd6, 8'd8);
        clk1();
        clk1();
        chk("mid_valid", 64'(pf_valid), 64'd1);
        chk("mid_addr", pf_addr, 64'h30C0);
        resetN = 1'b0;
        #1;
        chk("rst_drop_valid", 64'(pf_valid), 64'd0);
        chk("rst_drop_addr", pf_addr, 64'd0);
        chk("rst_drop_active", 64'(str_active), 64'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        pf_ready = 1'b1;
        repeat (10) clk1();
        chk("post_rst_idle", 64'(pf_valid), 64'd0);
        chk("post_rst_sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_stream_prefetch_ctrl.md
MULTI_STREAM_PREFETCH_CTRL -- requirements
Module: multi_stream_prefetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 64, address width.
REQ-002 SHALL have parameter BURST_LEN_WIDTH, default 8, burst length width.
REQ-003 SHALL have parameter TID_WIDTH, default 8, transaction ID width.
REQ-004 SHALL have parameter NUM_STREAMS, default 4, number of independent stride slots (power of 2, >=2).
REQ-005 SHALL have parameter LOG_QUEUE_SIZE, default 6, per-stream queue depth log2.
REQ-006 SHALL have parameter WATCHDOG_SIZE, default 10, watchdog prescaler width.
REQ-007 SHALL have parameter CONF_BITS, default 2, confidence counter width.
REQ-008 Ports, in this order:
- clk, in, 1, single clock.
- resetN, in, 1, asynchronous active-low reset.
- en, in, 1, state update enable.
- flushN, in, 1, active-low flush of all streams.
- obs_valid / obs_addr / obs_id / obs_len, in, 1 / ADDR_BITS / TID_WIDTH / BURST_LEN_WIDTH, observed accepted read request.
- bar / limit, in, ADDR_BITS each, inclusive prefetch range.
- windowSize, in, LOG_QUEUE_SIZE+1, max outstanding prefetches per stream.
- confThreshold, in, CONF_BITS, equal strides needed to activate.
- watchdogCnt, in, WATCHDOG_SIZE, watchdog prescale.
- str_reqCnt, in, NUM_STREAMS x (LOG_QUEUE_SIZE+1), per-stream prefetch occupancy.
- str_drained, in, NUM_STREAMS, per-stream queue empty with no outstanding.
- pf_valid / pf_ready, out / in, 1 each, prefetch request handshake.
- pf_addr / pf_len / pf_id / pf_stream, out, ADDR_BITS / BURST_LEN_WIDTH / TID_WIDTH / log2(NUM_STREAMS), prefetch request.
- str_flushN, out, NUM_STREAMS, one-cycle low pulse flushing a stream's queue.
- str_active, out, NUM_STREAMS, stream in ACTIVE state.

Function
REQ-009 Hit: obs_valid with bar <= obs_addr <= limit (unsigned). Matching uses obs_id against non-IDLE slots. Hits with no match allocate the lowest-index IDLE slot. If no slot is IDLE, the request is ignored.
REQ-010 Per-stream FSM: IDLE, TRAIN, ACTIVE, CLEANUP.
REQ-011 IDLE -> TRAIN on allocation. Latch lastAddr=obs_addr, id, len; set stride=0, conf=0.
REQ-012 TRAIN, on matching hit with delta=obs_addr-lastAddr:
- delta=0: ignored.
- delta equals stride: conf increments, saturating.
- otherwise: stride=delta, conf=0.
- lastAddr updates in all cases.
REQ-013 TRAIN -> ACTIVE in the cycle the updated conf >= confThreshold. pfAddr=obs_addr+stride.
REQ-014 ACTIVE -> CLEANUP on any of:
- a matching hit with nonzero delta != stride;
- obs_len != len;
- obs_valid out of range with obs_id == id.
REQ-015 Arithmetic SHALL be modulo 2^ADDR_BITS two's complement, so negative strides are supported.
REQ-016 CLEANUP waits for str_drained[i]=1. It then drives str_flushN[i]=0 for exactly one cycle and returns to IDLE.
REQ-017 Eligibility for a stream: ACTIVE, str_reqCnt[i] < windowSize, and bar <= pfAddr <= limit.
REQ-018 Arbitration SHALL be round-robin, starting at rrPtr. After an accept, rrPtr = granted+1 mod NUM_STREAMS.
REQ-019 pf_* outputs SHALL be registered. pf_valid asserts one cycle after eligibility is found.
REQ-020 While pf_valid=1 and pf_ready=0, all pf_* outputs SHALL hold stable, even if the stream leaves ACTIVE.
REQ-021 On accept (pf_valid & pf_ready), stream pfAddr += stride. A new request MAY issue the next cycle.
REQ-022 Watchdog:
- Each tick, every non-IDLE stream's 2-bit idle counter increments.
- A matching hit clears it.
- Reaching 3 forces CLEANUP.
REQ-023 If a matching hit and an accept occur in the same cycle for the same stream, both updates SHALL apply.
REQ-024 flushN=0 forces every TRAIN/ACTIVE stream to CLEANUP next cycle. Allocation is blocked while flushN=0.
REQ-025 With en=0, all state SHALL hold, and no handshake SHALL complete besides holding pf_valid.

Reset
REQ-026 On resetN=0, asynchronously:
- All streams IDLE; conf, stride, lastAddr, pfAddr = 0.
- rrPtr=0.
- pf_valid=0, pf_addr/pf_len/pf_id/pf_stream=0.
- str_flushN all 1, str_active all 0.
REQ-027 Reset mid-request SHALL drop pf_valid with no accept counted.

Structure
REQ-028 The stream state enum, the pf opcode constants, and the default widths SHALL live in shared package prefetcher_pkg.
REQ-029 The watchdog tick SHALL come from one instance of the existing clkDivN sub-module (WIDTH=WATCHDOG_SIZE). Per-stream logic SHALL be a generate loop, not a sub-module.

Verification
REQ-030 Activation: confThreshold=1, id=3, reads at 0x1000, 0x1040, 0x1080, pf_ready=1 -> stream 0 ACTIVE; pf_addr 0x10C0, 0x1100, ... until str_reqCnt reaches windowSize=4.
REQ-031 Negative stride: reads at 0x2000, 0x1FC0, 0x1F80 -> pf_addr 0x1F40. With bar=0x1F40, no request below 0x1F40.
REQ-032 Round-robin: two ACTIVE streams, ids 1 and 2, pf_ready=1 -> pf_stream alternates 0,1,0,1. With pf_ready=0 for 5 cycles, pf_* stay stable.
REQ-033 Stride break: ACTIVE stream with stride 0x40 sees delta 0x80 -> CLEANUP. str_flushN pulses low one cycle after str_drained=1, then IDLE.
REQ-034 Overflow/flush: 5 distinct ids with NUM_STREAMS=4 -> 5th ignored. flushN=0 -> all 4 enter CLEANUP, and each pulses str_flushN once.
REQ-035 Watchdog/reset: watchdogCnt=2, no hits -> CLEANUP after 3 ticks. resetN low with pf_valid=1 -> pf_valid=0 immediately.
